mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency line memory responder for a cache refill/writeback port
//
// Purpose: accepts one 64-byte line request at a time, waits MEM_DELAY cycles,
// then returns a response. Writes store the line and mark it written; reads of
// never-written lines return an address pattern (word i = line base + 4*i).
//
// Optional feature macro: MEM_RESP_ALIGN_CHECK_EN
//   defined   -> requests with req_addr[5:0] != 0 complete with resp_err=1,
//                resp_rdata=0 and leave storage untouched
//   undefined -> resp_err is tied 0 and req_addr[5:0] is ignored
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   req_valid/ready   request handshake; req_ready is high only in IDLE
//   req_we            1 = writeback, 0 = fill
//   req_addr[31:0]    byte address; line index = req_addr[6 +: LINE_INDEX_BITS]
//   req_wdata[511:0]  writeback line, word i at [32*i +: 32]
//   resp_valid/ready  response handshake; outputs held until accepted
//   resp_rdata[511:0] fill data (0 for writes and errors)
//   resp_err          error flag qualified by resp_valid

module mem_responder #(
    parameter int MEM_DELAY       = 20,
    parameter int LINE_INDEX_BITS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [31:0]  req_addr,
    input  logic [511:0] req_wdata,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [511:0] resp_rdata,
    output logic         resp_err
);

    localparam int NUM_LINES = 1 << LINE_INDEX_BITS;
    // Counter only needs to reach MEM_DELAY; never wraps inside WAIT.
    localparam int CNT_W     = (MEM_DELAY < 1) ? 1 : $clog2(MEM_DELAY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_DELAY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                       r_state;
    logic [CNT_W-1:0]             r_cnt;
    logic                         r_we;
    logic [31:0]                  r_addr;
    logic [511:0]                 r_wdata;
    logic [NUM_LINES-1:0]         r_written;
    logic [511:0]                 r_mem [NUM_LINES];
    logic                         r_req_ready;
    logic                         r_resp_valid;
    logic [511:0]                 r_resp_rdata;
    logic                         r_resp_err;

    logic [LINE_INDEX_BITS-1:0]   w_idx;
    logic [511:0]                 w_pattern;
    logic                         w_misaligned;
    logic                         w_commit;

    assign w_idx = r_addr[6 +: LINE_INDEX_BITS];

`ifdef MEM_RESP_ALIGN_CHECK_EN
    assign w_misaligned = (r_addr[5:0] != 6'd0);
    assign resp_err     = r_resp_err;
`else
    // Low address bits and the error register carry no meaning in this build.
    logic w_unused_addr_lo;
    assign w_unused_addr_lo = &{1'b0, r_addr[5:0], r_resp_err};
    assign w_misaligned     = 1'b0;
    assign resp_err         = 1'b0;
`endif

    // Pattern for unwritten lines uses the full (unaliased) captured address.
    always_comb begin
        w_pattern = '0;
        for (int i = 0; i < 16; i++) begin
            w_pattern[32*i +: 32] = {r_addr[31:6], 6'd0} + 32'(4 * i);
        end
    end

    // Write commit happens on the WAIT->RESP edge only, so a reset during
    // WAIT leaves storage untouched.
    assign w_commit = !rst && (r_state == WAIT) && (r_cnt == CNT_LAST)
                      && r_we && !w_misaligned;

    // Line storage has no reset; the written bits gate its visibility.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_written    <= '0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_we        <= req_we;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_cnt       <= '0;
                        r_req_ready <= 1'b0;
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= w_misaligned;
                        if (w_misaligned || r_we) begin
                            r_resp_rdata <= '0;
                        end else if (r_written[w_idx]) begin
                            r_resp_rdata <= r_mem[w_idx];
                        end else begin
                            r_resp_rdata <= w_pattern;
                        end
                        if (r_we && !w_misaligned) begin
                            r_written[w_idx] <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;

endmodule
